mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clock and reset SHALL be: clk  in  1  single clock, all state updates on rising edge; rst  in  1  asynchronous, active-low reset.
REQ-002 Fetch port SHALL be: if_req in 1 fetch request; if_addr in 32 word address; if_gnt out 1 request accepted; if_rvalid out 1 read done; if_rdata out 32 fetched word.
REQ-003 Load/store port SHALL be: ls_req in 1; ls_addr in 32; ls_we in 1 (1 = store); ls_bs in 2 (01 byte, 10 half, 11 word); ls_wdata in 32; ls_gnt out 1; ls_rvalid out 1 completion; ls_rdata out 32.
REQ-004 Memory port SHALL be: mem_req out 1; mem_addr out 32; mem_we out 1; mem_bs out 2; mem_wdata out 32; mem_ready in 1 access done this cycle; mem_rdata in 32 (valid when mem_ready=1).
REQ-005 Status SHALL be: busy out 1, high whenever the state is not IDLE.

Function
REQ-006 FSM SHALL have states IDLE, IF_BUSY, LS_BUSY; exactly one memory access outstanding at any time.
REQ-007 In IDLE, if_gnt/ls_gnt SHALL be combinational; a request is accepted on the rising edge where req=1 and gnt=1; no gnt is asserted outside IDLE.
REQ-008 Fixed priority SHALL apply: both requesting -> ls_gnt=1, if_gnt=0.
REQ-009 On acceptance, addr/we/bs/wdata SHALL be captured into registers; fetch captures we=0, bs=11, wdata=0; next state IF_BUSY or LS_BUSY.
REQ-010 In *_BUSY, mem_req=1 and mem_addr/we/bs/wdata SHALL drive the captured values, stable until the cycle where mem_ready=1.
REQ-011 In *_BUSY with mem_ready=1, the next state SHALL be IDLE, and the matching *_rvalid SHALL pulse high for exactly the following cycle.
REQ-012 On an access that completes with mem_ready=1, *_rdata SHALL register mem_rdata for a read and register 0 for a store; *_rdata SHALL hold its value until the next completion.
REQ-013 ls_rvalid SHALL pulse for both loads and stores; if_rvalid SHALL never pulse for a load/store access.
REQ-014 Minimum latency SHALL be: accept at edge N; mem_req high in cycle N+1; mem_ready high in N+1 -> *_rvalid high in N+2. Each extra mem_ready-low cycle adds 1.
REQ-015 The IDLE cycle that carries an rvalid pulse SHALL also accept a new request, giving back-to-back accesses every 2 cycles.
REQ-016 mem_ready SHALL be ignored in IDLE.
REQ-017 Requests deasserted before a grant SHALL be dropped without side effects; requesters hold req/addr/data until gnt.

Reset
REQ-018 While rst=0, outputs SHALL be immediately (asynchronously) forced to: state IDLE, mem_req=0, mem_addr=0, mem_we=0, mem_bs=00, mem_wdata=0, both gnt=0, both rvalid=0, both rdata=0, busy=0.
REQ-019 Reset mid-access SHALL abandon the in-flight access; no rvalid SHALL pulse for it after reset deasserts.
REQ-020 After rst rises, the first acceptance SHALL occur at the first rising edge with a request.

Configuration
REQ-021 Macro ARB_RR_EN SHALL select arbitration policy.
REQ-022 Without ARB_RR_EN, the fixed priority of REQ-008 SHALL apply.
REQ-023 With ARB_RR_EN, a last_owner register (reset value = IF) SHALL be kept. When both request, the owner not equal to last_owner SHALL be granted. last_owner SHALL update at each acceptance. A single requester SHALL always be granted.

Verification
REQ-024 Single fetch: if_req=1, if_addr=0x100, mem_ready high 1st busy cycle, mem_rdata=0x00500093 -> if_gnt at N, mem_addr=0x100 at N+1, if_rvalid and if_rdata=0x00500093 at N+2.
REQ-025 Store with wait states: ls_we=1, ls_bs=01, ls_addr=0x2003, ls_wdata=0xAB, mem_ready low 3 cycles -> mem signals stable 4 cycles, ls_rvalid once, ls_rdata=0.
REQ-026 Contention: both requesting continuously for 4 accesses -> default build LS,LS,LS,LS; ARB_RR_EN build LS,IF,LS,IF.
REQ-027 Reset mid-access: assert rst=0 during LS_BUSY with mem_ready low -> mem_req falls without a clock edge, busy=0, no ls_rvalid after release.
REQ-028 Back-to-back: if_req held high, mem_ready always 1 -> if_gnt every 2nd cycle, if_rvalid coincident with the next if_gnt.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals for mem_arbiter.
// master: arbiter view; slave: requesters and memory model view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_we;
    logic [1:0]  ls_bs;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_bs;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_addr, ls_we, ls_bs, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_addr, mem_we, mem_bs, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_addr, ls_we, ls_bs, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_addr, mem_we, mem_bs, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch, load/store) arbiter onto a single memory port, one access in flight.
// Define ARB_RR_EN for alternating arbitration under contention; default is load/store priority.
module mem_arbiter (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    mem_arbiter_if.master        bus,
    output logic                 busy_o
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  bs_q;
    logic [31:0] wdata_q;
    logic        if_rvalid_q, ls_rvalid_q;
    logic [31:0] if_rdata_q, ls_rdata_q;
    logic        ls_pick;
    logic        if_gnt, ls_gnt;
    logic        idle;

    assign idle = (state_q == IDLE);

`ifdef ARB_RR_EN
    // last_ls_q = 1 when the load/store port owned the most recent acceptance
    logic last_ls_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)     last_ls_q <= 1'b0;
        else if (ls_gnt) last_ls_q <= 1'b1;
        else if (if_gnt) last_ls_q <= 1'b0;
    end

    assign ls_pick = bus.ls_req && (!bus.if_req || !last_ls_q);
`else
    assign ls_pick = bus.ls_req;
`endif

    // Grants are gated by reset so they drop asynchronously with it
    assign ls_gnt = rst_ni && idle && ls_pick;
    assign if_gnt = rst_ni && idle && bus.if_req && !ls_pick;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ls_gnt)      state_d = LS_BUSY;
                else if (if_gnt) state_d = IF_BUSY;
            end
            IF_BUSY, LS_BUSY: begin
                if (bus.mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            bs_q        <= '0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if (ls_gnt) begin
                addr_q  <= bus.ls_addr;
                we_q    <= bus.ls_we;
                bs_q    <= bus.ls_bs;
                wdata_q <= bus.ls_wdata;
            end else if (if_gnt) begin
                addr_q  <= bus.if_addr;
                we_q    <= 1'b0;
                bs_q    <= 2'b11;
                wdata_q <= '0;
            end
            if (bus.mem_ready) begin
                if (state_q == IF_BUSY) begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= bus.mem_rdata;
                end else if (state_q == LS_BUSY) begin
                    ls_rvalid_q <= 1'b1;
                    ls_rdata_q  <= we_q ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;

    assign bus.mem_req   = !idle;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_bs    = bs_q;
    assign bus.mem_wdata = wdata_q;
    assign busy_o        = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expected values are hand-computed.
module tb_mem_arbiter;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic busy_o;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus),
        .busy_o (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        bit exp_ls;
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        bus.ls_req = 1'b0; bus.ls_addr = 32'h0; bus.ls_we = 1'b0;
        bus.ls_bs = 2'b00; bus.ls_wdata = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0;
        rst_ni = 1'b0;
        #12;
        // reset state, with a pending fetch request that must not be granted
        check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_busy",    {31'b0, busy_o}, 32'd0);
        check("rst_if_gnt",  {31'b0, bus.if_gnt}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_rvalid",  {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
        check("rst_rdata",   bus.if_rdata | bus.ls_rdata, 32'h0);
        bus.if_req = 1'b0;
        rst_ni = 1'b1;
        tick();

        // single fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00500093;
        #1;
        check("f_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        check("f_ls_gnt", {31'b0, bus.ls_gnt}, 32'd0);
        tick();
        bus.if_req = 1'b0; bus.if_addr = 32'hFFFF_FFFF;
        check("f_mem_req",  {31'b0, bus.mem_req}, 32'd1);
        check("f_busy",     {31'b0, busy_o}, 32'd1);
        check("f_mem_addr", bus.mem_addr, 32'h100);
        check("f_mem_ctl",  {bus.mem_we, bus.mem_bs}, 32'b011);
        check("f_mem_wdata", bus.mem_wdata, 32'h0);
        tick();
        check("f_if_rvalid", {31'b0, bus.if_rvalid}, 32'd1);
        check("f_if_rdata",  bus.if_rdata, 32'h00500093);
        check("f_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
        check("f_idle",      {31'b0, busy_o}, 32'd0);
        bus.mem_ready = 1'b0;
        tick();
        check("f_rvalid_end", {31'b0, bus.if_rvalid}, 32'd0);
        check("f_rdata_hold", bus.if_rdata, 32'h00500093);

        // halfword load
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_bs = 2'b10; bus.ls_addr = 32'h40;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
        #1;
        check("ld_ls_gnt", {31'b0, bus.ls_gnt}, 32'd1);
        tick();
        bus.ls_req = 1'b0;
        check("ld_mem", {bus.mem_addr[7:0], 21'b0, bus.mem_we, bus.mem_bs}, {8'h40, 24'h2});
        tick();
        check("ld_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd1);
        check("ld_if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        check("ld_ls_rdata",  bus.ls_rdata, 32'h12345678);
        check("ld_if_rdata",  bus.if_rdata, 32'h00500093);
        bus.mem_ready = 1'b0;
        tick();

        // byte store with three wait states
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_bs = 2'b01;
        bus.ls_addr = 32'h2003; bus.ls_wdata = 32'hAB;
        #1;
        check("st_ls_gnt", {31'b0, bus.ls_gnt}, 32'd1);
        tick();
        bus.ls_req = 1'b0; bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0; bus.ls_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
            end
            check("st_mem_req",  {31'b0, bus.mem_req}, 32'd1);
            check("st_mem_addr", bus.mem_addr, 32'h2003);
            check("st_mem_ctl",  {bus.mem_we, bus.mem_bs}, 32'b101);
            check("st_mem_wdata", bus.mem_wdata, 32'hAB);
            check("st_no_rvalid", {31'b0, bus.ls_rvalid}, 32'd0);
            tick();
        end
        check("st_ls_rvalid", {31'b0, bus.ls_rvalid}, 32'd1);
        check("st_ls_rdata",  bus.ls_rdata, 32'h0);
        bus.mem_ready = 1'b0;
        tick();
        check("st_rvalid_once", {31'b0, bus.ls_rvalid}, 32'd0);

        // reset in the middle of a stalled load
        bus.ls_req = 1'b1; bus.ls_addr = 32'h80;
        tick();
        bus.ls_req = 1'b0;
        check("mr_busy_before", {31'b0, busy_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mr_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("mr_busy",    {31'b0, busy_o}, 32'd0);
        check("mr_mem_addr", bus.mem_addr, 32'h0);
        check("mr_if_rdata", bus.if_rdata, 32'h0);
        bus.mem_ready = 1'b1;
        tick();
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mr_no_rvalid", {30'b0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
        end

        // contention, both ports requesting continuously
        bus.if_req = 1'b1; bus.if_addr = 32'h1000;
        bus.ls_req = 1'b1; bus.ls_addr = 32'h3000; bus.ls_we = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA55AA;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_ls = (k % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            #1;
            check("ct_ls_gnt", {31'b0, bus.ls_gnt}, {31'b0, exp_ls});
            check("ct_if_gnt", {31'b0, bus.if_gnt}, {31'b0, !exp_ls});
            tick();
            check("ct_mem_addr", bus.mem_addr, exp_ls ? 32'h3000 : 32'h1000);
            tick();
            check("ct_rvalid", {30'b0, bus.ls_rvalid, bus.if_rvalid}, {30'b0, exp_ls, !exp_ls});
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        tick();

        // back-to-back fetches with a zero-wait memory
        bus.if_req = 1'b1; bus.if_addr = 32'h200; bus.mem_rdata = 32'hCAFE0001;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("bb_if_gnt",    {31'b0, bus.if_gnt}, {31'b0, (c % 2 == 0)});
            check("bb_if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, (c % 2 == 0) && (c > 0)});
            if (c == 2) check("bb_if_rdata", bus.if_rdata, 32'hCAFE0001);
            tick();
        end
        bus.if_req = 1'b0; bus.mem_ready = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
